// File: rtl/mem_bus_pkg.sv
// Shared types and access-code helpers for the memory bus arbiter.
// Access codes come from the memory stage; sizes drive lane and alignment logic.
package mem_bus_pkg;

  typedef enum logic [3:0] {
    MEM_NONE = 4'd0,
    MEM_LB   = 4'd1,
    MEM_LH   = 4'd2,
    MEM_LW   = 4'd3,
    MEM_LBU  = 4'd4,
    MEM_LHU  = 4'd5,
    MEM_SB   = 4'd6,
    MEM_SH   = 4'd7,
    MEM_SW   = 4'd8
  } mem_rw_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUS_DM,
    ST_BUS_IF,
    ST_IF_DRAIN
  } arb_state_t;

  typedef enum logic [1:0] {
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD,
    SZ_NONE
  } acc_size_t;

  function automatic acc_size_t rw_size(logic [3:0] rw);
    case (rw)
      MEM_LB, MEM_LBU, MEM_SB: rw_size = SZ_BYTE;
      MEM_LH, MEM_LHU, MEM_SH: rw_size = SZ_HALF;
      MEM_LW, MEM_SW:          rw_size = SZ_WORD;
      default:                 rw_size = SZ_NONE;
    endcase
  endfunction

  function automatic logic rw_is_store(logic [3:0] rw);
    return (rw == MEM_SB) || (rw == MEM_SH) || (rw == MEM_SW);
  endfunction

  function automatic logic rw_is_signed(logic [3:0] rw);
    return (rw == MEM_LB) || (rw == MEM_LH);
  endfunction

  // MEM_NONE and unused codes are reported the same way as a misaligned access.
  function automatic logic rw_bad_access(logic [3:0] rw, logic [1:0] lane);
    case (rw_size(rw))
      SZ_BYTE: rw_bad_access = 1'b0;
      SZ_HALF: rw_bad_access = lane[0];
      SZ_WORD: rw_bad_access = |lane;
      default: rw_bad_access = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Requester and memory-bus signal bundle for mem_bus_arbiter.
// master = arbiter side, slave = fetch/memory stage plus memory side.
interface mem_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic              if_kill_i;
  logic [DATA_W-1:0] if_rdata_o;
  logic              if_valid_o;

  logic              dm_req_i;
  logic [ADDR_W-1:0] dm_addr_i;
  logic [DATA_W-1:0] dm_wdata_i;
  logic [3:0]        dm_mem_rw_i;
  logic [DATA_W-1:0] dm_rdata_o;
  logic              dm_valid_o;
  logic              dm_err_o;

  logic              stall_if_o;
  logic              stall_mem_o;

  logic              bus_req_o;
  logic              bus_we_o;
  logic [3:0]        bus_be_o;
  logic [ADDR_W-1:0] bus_addr_o;
  logic [DATA_W-1:0] bus_wdata_o;
  logic [DATA_W-1:0] bus_rdata_i;
  logic              bus_ack_i;

  modport master (
    input  if_req_i, if_addr_i, if_kill_i,
    input  dm_req_i, dm_addr_i, dm_wdata_i, dm_mem_rw_i,
    input  bus_rdata_i, bus_ack_i,
    output if_rdata_o, if_valid_o,
    output dm_rdata_o, dm_valid_o, dm_err_o,
    output stall_if_o, stall_mem_o,
    output bus_req_o, bus_we_o, bus_be_o, bus_addr_o, bus_wdata_o
  );

  modport slave (
    output if_req_i, if_addr_i, if_kill_i,
    output dm_req_i, dm_addr_i, dm_wdata_i, dm_mem_rw_i,
    output bus_rdata_i, bus_ack_i,
    input  if_rdata_o, if_valid_o,
    input  dm_rdata_o, dm_valid_o, dm_err_o,
    input  stall_if_o, stall_mem_o,
    input  bus_req_o, bus_we_o, bus_be_o, bus_addr_o, bus_wdata_o
  );
endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane handling for a 32-bit bus: store enables/replication, load
// lane select with sign/zero extension, and bad-access detection.
module mem_lane_align
  import mem_bus_pkg::*;
(
  input  logic [3:0]  req_rw_i,
  input  logic [1:0]  req_lane_i,
  input  logic [31:0] req_wdata_i,
  output logic [3:0]  req_be_o,
  output logic [31:0] req_wdata_o,
  output logic        req_we_o,
  output logic        req_err_o,

  input  logic [3:0]  rsp_rw_i,
  input  logic [1:0]  rsp_lane_i,
  input  logic [31:0] rsp_rdata_i,
  output logic [31:0] rsp_rdata_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    req_be_o    = 4'b0000;
    req_wdata_o = '0;
    req_we_o    = rw_is_store(req_rw_i);
    req_err_o   = rw_bad_access(req_rw_i, req_lane_i);
    case (rw_size(req_rw_i))
      SZ_BYTE: begin
        req_be_o    = 4'b0001 << req_lane_i;
        req_wdata_o = {4{req_wdata_i[7:0]}};
      end
      SZ_HALF: begin
        req_be_o    = 4'b0011 << req_lane_i;
        req_wdata_o = {2{req_wdata_i[15:0]}};
      end
      SZ_WORD: begin
        req_be_o    = 4'b1111;
        req_wdata_o = req_wdata_i;
      end
      default: ;
    endcase
    // Loads drive zero data so the bus never carries stale store values.
    if (!req_we_o) begin
      req_wdata_o = '0;
    end
  end

  always_comb begin
    byte_sel = rsp_rdata_i[7:0];
    case (rsp_lane_i)
      2'd0: byte_sel = rsp_rdata_i[7:0];
      2'd1: byte_sel = rsp_rdata_i[15:8];
      2'd2: byte_sel = rsp_rdata_i[23:16];
      2'd3: byte_sel = rsp_rdata_i[31:24];
      default: ;
    endcase
    half_sel = rsp_lane_i[1] ? rsp_rdata_i[31:16] : rsp_rdata_i[15:0];

    rsp_rdata_o = '0;
    if (!rw_is_store(rsp_rw_i)) begin
      case (rw_size(rsp_rw_i))
        SZ_BYTE: rsp_rdata_o = rw_is_signed(rsp_rw_i) ? {{24{byte_sel[7]}}, byte_sel}
                                                       : {24'h0, byte_sel};
        SZ_HALF: rsp_rdata_o = rw_is_signed(rsp_rw_i) ? {{16{half_sel[15]}}, half_sel}
                                                       : {16'h0, half_sel};
        SZ_WORD: rsp_rdata_o = rsp_rdata_i;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Single-port memory bus shared by instruction fetch and the memory stage.
// DM wins over IF; bus outputs are registered and held until bus_ack_i.
//
//  state       | meaning
//  ------------+------------------------------------------------------------
//  ST_IDLE     | no bus cycle; arbitrate DM first, then IF
//  ST_BUS_DM   | data access on the bus, waiting for ack
//  ST_BUS_IF   | fetch on the bus, waiting for ack
//  ST_IF_DRAIN | fetch killed; bus cycle finishes, result dropped
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  mem_bus_arbiter_if.master   bus
);

  localparam logic [ADDR_W-1:0] ADDR_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

  arb_state_t        state_q, state_d;
  logic              bus_req_q, bus_req_d;
  logic              we_q, we_d;
  logic [3:0]        be_q, be_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        rw_q, rw_d;
  logic [1:0]        lane_q, lane_d;
  logic              if_valid_q, if_valid_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic              dm_valid_q, dm_valid_d;
  logic              dm_err_q, dm_err_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;

  logic [3:0]        st_be;
  logic [DATA_W-1:0] st_wdata;
  logic              st_we;
  logic              st_err;
  logic [DATA_W-1:0] ld_data;
  logic              dm_pending;
  logic              if_pending;

  mem_lane_align u_align (
    .req_rw_i    (bus.dm_mem_rw_i),
    .req_lane_i  (bus.dm_addr_i[1:0]),
    .req_wdata_i (bus.dm_wdata_i),
    .req_be_o    (st_be),
    .req_wdata_o (st_wdata),
    .req_we_o    (st_we),
    .req_err_o   (st_err),
    .rsp_rw_i    (rw_q),
    .rsp_lane_i  (lane_q),
    .rsp_rdata_i (bus.bus_rdata_i),
    .rsp_rdata_o (ld_data)
  );

  // A requester still shows req during its valid cycle; that request is done.
  assign dm_pending = bus.dm_req_i & ~dm_valid_q;
  assign if_pending = bus.if_req_i & ~if_valid_q & ~bus.if_kill_i;

  always_comb begin
    state_d    = state_q;
    bus_req_d  = bus_req_q;
    we_d       = we_q;
    be_d       = be_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rw_d       = rw_q;
    lane_d     = lane_q;
    if_valid_d = 1'b0;
    if_rdata_d = if_rdata_q;
    dm_valid_d = 1'b0;
    dm_err_d   = 1'b0;
    dm_rdata_d = dm_rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (dm_pending) begin
          if (st_err) begin
            dm_valid_d = 1'b1;
            dm_err_d   = 1'b1;
            dm_rdata_d = '0;
          end else begin
            state_d   = ST_BUS_DM;
            bus_req_d = 1'b1;
            we_d      = st_we;
            be_d      = st_be;
            addr_d    = bus.dm_addr_i & ADDR_MASK;
            wdata_d   = st_wdata;
            rw_d      = bus.dm_mem_rw_i;
            lane_d    = bus.dm_addr_i[1:0];
          end
        end else if (if_pending) begin
          state_d   = ST_BUS_IF;
          bus_req_d = 1'b1;
          we_d      = 1'b0;
          be_d      = 4'hF;
          addr_d    = bus.if_addr_i & ADDR_MASK;
          wdata_d   = '0;
        end
      end
      ST_BUS_DM: begin
        if (bus.bus_ack_i) begin
          state_d    = ST_IDLE;
          bus_req_d  = 1'b0;
          we_d       = 1'b0;
          be_d       = 4'h0;
          dm_valid_d = 1'b1;
          dm_rdata_d = ld_data;
        end
      end
      ST_BUS_IF: begin
        if (bus.bus_ack_i) begin
          state_d   = ST_IDLE;
          bus_req_d = 1'b0;
          be_d      = 4'h0;
          if (!bus.if_kill_i) begin
            if_valid_d = 1'b1;
            if_rdata_d = bus.bus_rdata_i;
          end
        end else if (bus.if_kill_i) begin
          state_d = ST_IF_DRAIN;
        end
      end
      ST_IF_DRAIN: begin
        if (bus.bus_ack_i) begin
          state_d   = ST_IDLE;
          bus_req_d = 1'b0;
          be_d      = 4'h0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      bus_req_q  <= 1'b0;
      we_q       <= 1'b0;
      be_q       <= 4'h0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rw_q       <= MEM_NONE;
      lane_q     <= 2'b00;
      if_valid_q <= 1'b0;
      if_rdata_q <= '0;
      dm_valid_q <= 1'b0;
      dm_err_q   <= 1'b0;
      dm_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      bus_req_q  <= bus_req_d;
      we_q       <= we_d;
      be_q       <= be_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rw_q       <= rw_d;
      lane_q     <= lane_d;
      if_valid_q <= if_valid_d;
      if_rdata_q <= if_rdata_d;
      dm_valid_q <= dm_valid_d;
      dm_err_q   <= dm_err_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end

  assign bus.bus_req_o   = bus_req_q;
  assign bus.bus_we_o    = we_q;
  assign bus.bus_be_o    = be_q;
  assign bus.bus_addr_o  = addr_q;
  assign bus.bus_wdata_o = wdata_q;
  assign bus.if_valid_o  = if_valid_q;
  assign bus.if_rdata_o  = if_rdata_q;
  assign bus.dm_valid_o  = dm_valid_q;
  assign bus.dm_err_o    = dm_err_q;
  assign bus.dm_rdata_o  = dm_rdata_q;
  assign bus.stall_if_o  = bus.if_req_i & ~if_valid_q;
  assign bus.stall_mem_o = bus.dm_req_i & ~dm_valid_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: table of single DM accesses plus
// hand sequences for arbitration, fetch kill and mid-transaction reset.
module tb_mem_bus_arbiter;
  import mem_bus_pkg::*;

  typedef struct {
    logic [3:0]  rw;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] brdata;
    logic        err;
    logic        we;
    logic [3:0]  be;
    logic [31:0] baddr;
    logic [31:0] bwdata;
    logic [31:0] rdata;
  } vec_t;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  vec_t vecs[13];

  mem_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bif ();

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] rw, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] brdata,
                              input logic err, input logic we, input logic [3:0] be,
                              input logic [31:0] baddr, input logic [31:0] bwdata,
                              input logic [31:0] rdata);
    vec_t v;
    v.rw = rw; v.addr = addr; v.wdata = wdata; v.brdata = brdata; v.err = err;
    v.we = we; v.be = be; v.baddr = baddr; v.bwdata = bwdata; v.rdata = rdata;
    return v;
  endfunction

  task automatic dm_start(input logic [3:0] rw, input logic [31:0] addr, input logic [31:0] wdata);
    bif.dm_req_i    = 1'b1;
    bif.dm_mem_rw_i = rw;
    bif.dm_addr_i   = addr;
    bif.dm_wdata_i  = wdata;
  endtask

  initial begin
    bif.if_req_i    = 1'b0;
    bif.if_addr_i   = '0;
    bif.if_kill_i   = 1'b0;
    bif.dm_req_i    = 1'b0;
    bif.dm_addr_i   = '0;
    bif.dm_wdata_i  = '0;
    bif.dm_mem_rw_i = MEM_NONE;
    bif.bus_rdata_i = '0;
    bif.bus_ack_i   = 1'b0;

    //            rw        addr          wdata         brdata        err we  be       baddr         bwdata        rdata
    vecs[0]  = mk(MEM_LW,  32'h100, 32'h0,        32'hDEADBEEF, 0, 0, 4'b1111, 32'h100, 32'h0,        32'hDEADBEEF);
    vecs[1]  = mk(MEM_LB,  32'h102, 32'h0,        32'h00800000, 0, 0, 4'b0100, 32'h100, 32'h0,        32'hFFFFFF80);
    vecs[2]  = mk(MEM_LBU, 32'h102, 32'h0,        32'h00800000, 0, 0, 4'b0100, 32'h100, 32'h0,        32'h00000080);
    vecs[3]  = mk(MEM_LW,  32'h102, 32'h0,        32'h11111111, 1, 0, 4'b0000, 32'h0,   32'h0,        32'h0);
    vecs[4]  = mk(MEM_LH,  32'h102, 32'h0,        32'hBEEF1234, 0, 0, 4'b1100, 32'h100, 32'h0,        32'hFFFFBEEF);
    vecs[5]  = mk(MEM_LHU, 32'h100, 32'h0,        32'hBEEF8234, 0, 0, 4'b0011, 32'h100, 32'h0,        32'h00008234);
    vecs[6]  = mk(MEM_LH,  32'h101, 32'h0,        32'h0,        1, 0, 4'b0000, 32'h0,   32'h0,        32'h0);
    vecs[7]  = mk(MEM_SB,  32'h103, 32'h000000A5, 32'h12345678, 0, 1, 4'b1000, 32'h100, 32'hA5A5A5A5, 32'h0);
    vecs[8]  = mk(MEM_SH,  32'h202, 32'h1234CAFE, 32'h0,        0, 1, 4'b1100, 32'h200, 32'hCAFECAFE, 32'h0);
    vecs[9]  = mk(MEM_LB,  32'h101, 32'h0,        32'h00007F00, 0, 0, 4'b0010, 32'h100, 32'h0,        32'h0000007F);
    vecs[10] = mk(MEM_SW,  32'h302, 32'h01234567, 32'h0,        1, 0, 4'b0000, 32'h0,   32'h0,        32'h0);
    vecs[11] = mk(MEM_SW,  32'h300, 32'h01234567, 32'h0,        0, 1, 4'b1111, 32'h300, 32'h01234567, 32'h0);
    vecs[12] = mk(MEM_NONE,32'h100, 32'h0,        32'h0,        1, 0, 4'b0000, 32'h0,   32'h0,        32'h0);

    rst = 1'b1;
    #23;
    chk("reset bus_req", {31'b0, bif.bus_req_o}, 32'h0);
    chk("reset bus_we", {31'b0, bif.bus_we_o}, 32'h0);
    chk("reset bus_be", {28'b0, bif.bus_be_o}, 32'h0);
    chk("reset bus_addr", bif.bus_addr_o, 32'h0);
    chk("reset valids/err", {29'b0, bif.if_valid_o, bif.dm_valid_o, bif.dm_err_o}, 32'h0);
    chk("reset dm_rdata", bif.dm_rdata_o, 32'h0);
    rst = 1'b0;
    tick();

    // Table: one DM access each, ack in the first cycle bus_req is seen.
    for (int i = 0; i < 13; i++) begin
      dm_start(vecs[i].rw, vecs[i].addr, vecs[i].wdata);
      #1;
      chk($sformatf("v%0d stall_mem pending", i), {31'b0, bif.stall_mem_o}, 32'h1);
      tick();
      if (vecs[i].err) begin
        chk($sformatf("v%0d err no bus_req", i), {31'b0, bif.bus_req_o}, 32'h0);
        chk($sformatf("v%0d err valid/err", i), {30'b0, bif.dm_valid_o, bif.dm_err_o}, 32'h3);
        chk($sformatf("v%0d err rdata", i), bif.dm_rdata_o, 32'h0);
      end else begin
        chk($sformatf("v%0d bus_req", i), {31'b0, bif.bus_req_o}, 32'h1);
        chk($sformatf("v%0d bus_we", i), {31'b0, bif.bus_we_o}, {31'b0, vecs[i].we});
        chk($sformatf("v%0d bus_be", i), {28'b0, bif.bus_be_o}, {28'b0, vecs[i].be});
        chk($sformatf("v%0d bus_addr", i), bif.bus_addr_o, vecs[i].baddr);
        if (vecs[i].we) chk($sformatf("v%0d bus_wdata", i), bif.bus_wdata_o, vecs[i].bwdata);
        chk($sformatf("v%0d no early valid", i), {31'b0, bif.dm_valid_o}, 32'h0);
        bif.bus_ack_i   = 1'b1;
        bif.bus_rdata_i = vecs[i].brdata;
        tick();
        bif.bus_ack_i = 1'b0;
        chk($sformatf("v%0d bus_req dropped", i), {31'b0, bif.bus_req_o}, 32'h0);
        chk($sformatf("v%0d valid/err", i), {30'b0, bif.dm_valid_o, bif.dm_err_o}, 32'h2);
        chk($sformatf("v%0d rdata", i), bif.dm_rdata_o, vecs[i].rdata);
      end
      chk($sformatf("v%0d stall_mem released", i), {31'b0, bif.stall_mem_o}, 32'h0);
      bif.dm_req_i = 1'b0;
      tick();
      chk($sformatf("v%0d valid one cycle", i), {31'b0, bif.dm_valid_o}, 32'h0);
      chk($sformatf("v%0d no re-grant", i), {31'b0, bif.bus_req_o}, 32'h0);
    end

    // LW with ack after 3 cycles; requester inputs change after grant.
    dm_start(MEM_LW, 32'h100, 32'h0);
    tick();
    chk("slow bus_req after 1", {31'b0, bif.bus_req_o}, 32'h1);
    bif.dm_addr_i   = 32'h0000_0F0F;
    bif.dm_mem_rw_i = MEM_SB;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("slow hold req c%0d", c), {31'b0, bif.bus_req_o}, 32'h1);
      chk($sformatf("slow hold addr c%0d", c), bif.bus_addr_o, 32'h100);
      chk($sformatf("slow hold we/valid c%0d", c), {30'b0, bif.bus_we_o, bif.dm_valid_o}, 32'h0);
    end
    bif.bus_ack_i   = 1'b1;
    bif.bus_rdata_i = 32'hDEADBEEF;
    tick();
    bif.bus_ack_i = 1'b0;
    chk("slow valid", {31'b0, bif.dm_valid_o}, 32'h1);
    chk("slow rdata latched LW", bif.dm_rdata_o, 32'hDEADBEEF);
    bif.dm_req_i = 1'b0;
    tick();
    chk("slow valid pulse", {31'b0, bif.dm_valid_o}, 32'h0);

    // Same-cycle IF 0x40 and DM SB 0x103: DM first, then IF.
    bif.if_req_i  = 1'b1;
    bif.if_addr_i = 32'h40;
    dm_start(MEM_SB, 32'h103, 32'h000000A5);
    tick();
    chk("arb dm first we", {31'b0, bif.bus_we_o}, 32'h1);
    chk("arb dm be", {28'b0, bif.bus_be_o}, 32'h8);
    chk("arb dm wdata", bif.bus_wdata_o, 32'hA5A5A5A5);
    chk("arb dm addr", bif.bus_addr_o, 32'h100);
    chk("arb stall_if", {31'b0, bif.stall_if_o}, 32'h1);
    bif.bus_ack_i = 1'b1;
    tick();
    bif.bus_ack_i = 1'b0;
    chk("arb dm valid", {31'b0, bif.dm_valid_o}, 32'h1);
    bif.dm_req_i = 1'b0;
    tick();
    chk("arb if granted req", {31'b0, bif.bus_req_o}, 32'h1);
    chk("arb if addr", bif.bus_addr_o, 32'h40);
    chk("arb if read", {27'b0, bif.bus_we_o, bif.bus_be_o}, 32'h0F);
    bif.bus_ack_i   = 1'b1;
    bif.bus_rdata_i = 32'h00000013;
    tick();
    bif.bus_ack_i = 1'b0;
    chk("arb if valid", {31'b0, bif.if_valid_o}, 32'h1);
    chk("arb if rdata", bif.if_rdata_o, 32'h00000013);
    chk("arb stall_if released", {31'b0, bif.stall_if_o}, 32'h0);
    bif.if_req_i = 1'b0;
    tick();
    chk("arb if valid pulse", {31'b0, bif.if_valid_o}, 32'h0);

    // Kill before ack: cycle drains, no if_valid; next fetch completes.
    bif.if_req_i  = 1'b1;
    bif.if_addr_i = 32'h40;
    tick();
    chk("kill fetch issued", {31'b0, bif.bus_req_o}, 32'h1);
    bif.if_kill_i = 1'b1;
    tick();
    bif.if_kill_i = 1'b0;
    bif.if_req_i  = 1'b0;
    chk("kill no abort", {31'b0, bif.bus_req_o}, 32'h1);
    tick();
    chk("drain still waiting", {31'b0, bif.bus_req_o}, 32'h1);
    bif.bus_ack_i   = 1'b1;
    bif.bus_rdata_i = 32'hBADBAD00;
    tick();
    bif.bus_ack_i = 1'b0;
    chk("drain done", {30'b0, bif.bus_req_o, bif.if_valid_o}, 32'h0);
    chk("drain rdata kept", bif.if_rdata_o, 32'h00000013);
    bif.if_req_i  = 1'b1;
    bif.if_addr_i = 32'h80;
    tick();
    chk("refetch addr", bif.bus_addr_o, 32'h80);
    bif.bus_ack_i   = 1'b1;
    bif.bus_rdata_i = 32'h11112222;
    tick();
    bif.bus_ack_i = 1'b0;
    chk("refetch valid", {31'b0, bif.if_valid_o}, 32'h1);
    chk("refetch rdata", bif.if_rdata_o, 32'h11112222);
    bif.if_req_i = 1'b0;
    tick();

    // Kill together with ack: valid suppressed, back to IDLE.
    bif.if_req_i  = 1'b1;
    bif.if_addr_i = 32'h44;
    tick();
    bif.if_kill_i   = 1'b1;
    bif.bus_ack_i   = 1'b1;
    bif.bus_rdata_i = 32'h55555555;
    tick();
    bif.if_kill_i = 1'b0;
    bif.bus_ack_i = 1'b0;
    bif.if_req_i  = 1'b0;
    chk("kill+ack no valid", {30'b0, bif.bus_req_o, bif.if_valid_o}, 32'h0);

    // Kill in IDLE: no grant that cycle.
    bif.if_req_i  = 1'b1;
    bif.if_kill_i = 1'b1;
    tick();
    chk("kill idle no grant", {31'b0, bif.bus_req_o}, 32'h0);
    bif.if_req_i  = 1'b0;
    bif.if_kill_i = 1'b0;
    tick();

    // Reset while BUS_DM waits for ack.
    dm_start(MEM_LW, 32'h100, 32'h0);
    tick();
    chk("rst pre bus_req", {31'b0, bif.bus_req_o}, 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("rst async bus_req", {31'b0, bif.bus_req_o}, 32'h0);
    chk("rst async valids", {29'b0, bif.if_valid_o, bif.dm_valid_o, bif.dm_err_o}, 32'h0);
    tick();
    bif.dm_req_i = 1'b0;
    rst = 1'b0;
    tick();
    chk("post rst idle", {30'b0, bif.bus_req_o, bif.dm_valid_o}, 32'h0);
    bif.if_req_i  = 1'b1;
    bif.if_addr_i = 32'h48;
    tick();
    chk("post rst if grant", bif.bus_addr_o, 32'h48);
    bif.bus_ack_i   = 1'b1;
    bif.bus_rdata_i = 32'hCAFE0001;
    tick();
    bif.bus_ack_i = 1'b0;
    chk("post rst if rdata", bif.if_rdata_o, 32'hCAFE0001);
    bif.if_req_i = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
